mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of the shared memory.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-low; all state cleared while low.
REQ-004 if_req  input  1  instruction-fetch request; held high until if_ack.
REQ-005 if_addr  input  ADDR_W  fetch byte address.
REQ-006 if_ack / if_err  output  1 / 1  fetch complete / fetch misaligned; single-cycle pulses.
REQ-007 if_rdata  output  32  fetched instruction; valid while if_ack=1.
REQ-008 d_rd / d_wr  input  1 / 1  data read / write request; held until d_ack; never both high.
REQ-009 d_funct3  input  3  access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; SB/SH/SW use 000/001/010).
REQ-010 d_addr / d_wdata  input  ADDR_W / 32  data byte address / store data.
REQ-011 d_ack / d_err  output  1 / 1  data access complete / data access misaligned; single-cycle pulses.
REQ-012 d_rdata  output  32  load data, as returned by memory; valid while d_ack=1 for reads.
REQ-013 stall  output  1  combinational: (if_req | d_rd | d_wr) and no ack pulse this cycle.
REQ-014 mem_re / mem_we  output  1 / 1  shared single-port memory read / write strobe; registered.
REQ-015 mem_addr / mem_funct3 / mem_wdata  output  ADDR_W / 3 / 32  registered memory command fields.
REQ-016 mem_rdata  input  32  memory read data, valid the cycle after mem_re=1.

Function
REQ-017 FSM states IDLE, ACCESS, CAPTURE, DONE; exactly one transaction in flight.
REQ-018 IDLE: no request -> stay; else arbitrate, register the winner's command into mem_*, go to ACCESS.
REQ-019 Arbitration: only one requester pending -> it wins; both pending -> requester not granted last wins; last_grant resets to data, so fetch wins first.
REQ-020 Fetch command: mem_addr=if_addr, mem_funct3=010, mem_re=1, mem_we=0.
REQ-021 ACCESS: mem_re or mem_we high for exactly this one cycle; read -> CAPTURE; write -> DONE.
REQ-022 CAPTURE: mem_rdata registered into the winner's rdata register; go to DONE.
REQ-023 DONE: winner's ack high for one cycle; go to IDLE; last_grant updated.
REQ-024 Latency from request seen in IDLE to ack: read 4 cycles (ack in 4th cycle after sampling edge), write 3.
REQ-025 Back-to-back: a request pending in the IDLE cycle after DONE is accepted in that cycle; no idle bubble beyond IDLE.
REQ-026 Misalignment is checked in IDLE: fetch with if_addr[1:0]!=0, word access with addr[1:0]!=0, or half access with addr[0]=1.
REQ-027 A misaligned request, if it wins arbitration, goes to DONE directly; ack and err pulse together; mem_re=mem_we=0 throughout; rdata=0.
REQ-028 Requests and fields sampled only in IDLE; changes during ACCESS/CAPTURE/DONE are ignored.
REQ-029 A request dropped before its ack completes normally; the ack still pulses.
REQ-030 if_rdata and d_rdata hold their last value between acks; mem_* outputs return to re=we=0 outside ACCESS.
REQ-031 Fields mem_addr/funct3/wdata are held from ACCESS until the next IDLE grant.
REQ-032 d_rd and d_wr both high is illegal; it is treated as a write.

Reset
REQ-033 rst low -> state IDLE, last_grant=data, all outputs 0 (mem_re, mem_we, acks, errs, rdata, mem_* fields), immediately and asynchronously.
REQ-034 Reset during ACCESS drops mem_we/mem_re in the same cycle; the aborted transaction never acks.
REQ-035 First grant possible on the first rising edge after rst returns high.

Verification
REQ-036 Fetch alone: if_req=1, if_addr=0x10, mem_rdata=0x00500093 in the CAPTURE cycle -> mem_re one cycle with mem_addr=0x10, if_ack on 4th cycle with if_rdata=0x00500093, stall=1 for the 3 cycles before it.
REQ-037 Store: d_wr=1, d_funct3=010, d_addr=0x20, d_wdata=0xDEADBEEF -> single mem_we cycle with those fields, d_ack on 3rd cycle, no mem_re.
REQ-038 Contention: if_req and d_rd held continuously from reset -> grant order fetch, data, fetch, data; acks never coincide.
REQ-039 Misaligned: d_rd=1, d_funct3=001, d_addr=0x21 -> d_ack and d_err together 2 cycles after sampling, d_rdata=0, mem_re/mem_we stay 0.
REQ-040 Reset abort: rst low during write ACCESS -> mem_we low same cycle, no d_ack; after release, a fresh read to 0x20 completes normally.
REQ-041 Back-to-back reads: d_rd held for two requests at 0x04 and 0x08 -> second mem_re exactly 4 cycles after the first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port and a data load/store port onto one
// shared single-port memory. Exactly one transaction is in flight at a time.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   if_req, if_addr          fetch request (held until if_ack) and byte address
//   if_ack, if_err, if_rdata fetch done / misaligned pulses, fetched word
//   d_rd, d_wr, d_funct3     data read / write request (held until d_ack), size
//   d_addr, d_wdata          data byte address, store data
//   d_ack, d_err, d_rdata    data done / misaligned pulses, load data
//   stall                    a request is pending and no ack pulses this cycle
//   mem_re, mem_we           registered memory strobes, high only in ACCESS
//   mem_addr, mem_funct3,
//   mem_wdata                registered memory command fields
//   mem_rdata                memory read data, valid the cycle after mem_re
//   dbg_state                current FSM state (IDLE=0 ACCESS=1 CAPTURE=2 DONE=3)
//
// Handshake: a requester raises its request with stable fields and keeps it
// high until its ack pulse. Fields are sampled only in IDLE when the request
// wins arbitration; anything that happens to the request afterwards is
// ignored and the ack still pulses once, for exactly one cycle.
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_funct3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] F3_WORD = 3'b010;

  state_t            r_state;
  logic              r_last_grant_data;  // 1: data port was granted last
  logic              r_grant_data;       // owner of the transaction in flight
  logic              r_is_read;
  logic              r_if_ack;
  logic              r_if_err;
  logic [31:0]       r_if_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [31:0]       r_d_rdata;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [2:0]        r_mem_funct3;
  logic [31:0]       r_mem_wdata;

  logic w_d_req;
  logic w_any_req;
  logic w_pick_data;
  logic w_if_mis;
  logic w_d_mis;
  logic w_pick_mis;

  assign w_d_req   = d_rd | d_wr;
  assign w_any_req = if_req | w_d_req;
  // Data wins when it is alone, or when both are pending and fetch went last.
  assign w_pick_data = w_d_req & (~if_req | ~r_last_grant_data);

  assign w_if_mis = (if_addr[1:0] != 2'b00);
  // funct3[1:0] encodes size: 10 word, 01 half, 00 byte (sign bit ignored).
  assign w_d_mis  = ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00)) ||
                    ((d_funct3[1:0] == 2'b01) && d_addr[0]);
  assign w_pick_mis = w_pick_data ? w_d_mis : w_if_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_last_grant_data <= 1'b1;
      r_grant_data      <= 1'b0;
      r_is_read         <= 1'b0;
      r_if_ack          <= 1'b0;
      r_if_err          <= 1'b0;
      r_if_rdata        <= '0;
      r_d_ack           <= 1'b0;
      r_d_err           <= 1'b0;
      r_d_rdata         <= '0;
      r_mem_re          <= 1'b0;
      r_mem_we          <= 1'b0;
      r_mem_addr        <= '0;
      r_mem_funct3      <= '0;
      r_mem_wdata       <= '0;
    end else begin
      // Pulses and strobes default low; each is raised for a single cycle.
      r_if_ack <= 1'b0;
      r_if_err <= 1'b0;
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_data <= w_pick_data;
            if (w_pick_mis) begin
              // Misaligned: never touch memory, complete with ack+err next cycle.
              r_state <= S_DONE;
              if (w_pick_data) begin
                r_d_ack   <= 1'b1;
                r_d_err   <= 1'b1;
                r_d_rdata <= '0;
              end else begin
                r_if_ack   <= 1'b1;
                r_if_err   <= 1'b1;
                r_if_rdata <= '0;
              end
            end else begin
              r_state <= S_ACCESS;
              if (w_pick_data) begin
                // Both strobes high is illegal and resolves to a write.
                r_mem_addr   <= d_addr;
                r_mem_funct3 <= d_funct3;
                r_mem_wdata  <= d_wdata;
                r_mem_re     <= ~d_wr;
                r_mem_we     <= d_wr;
                r_is_read    <= ~d_wr;
              end else begin
                r_mem_addr   <= if_addr;
                r_mem_funct3 <= F3_WORD;
                r_mem_re     <= 1'b1;
                r_is_read    <= 1'b1;
              end
            end
          end
        end
        S_ACCESS: begin
          if (r_is_read) begin
            r_state <= S_CAPTURE;
          end else begin
            // Only the data port can write.
            r_state <= S_DONE;
            r_d_ack <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_state <= S_DONE;
          if (r_grant_data) begin
            r_d_rdata <= mem_rdata;
            r_d_ack   <= 1'b1;
          end else begin
            r_if_rdata <= mem_rdata;
            r_if_ack   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state           <= S_IDLE;
          r_last_grant_data <= r_grant_data;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ack     = r_if_ack;
  assign if_err     = r_if_err;
  assign if_rdata   = r_if_rdata;
  assign d_ack      = r_d_ack;
  assign d_err      = r_d_err;
  assign d_rdata    = r_d_rdata;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_funct3 = r_mem_funct3;
  assign mem_wdata  = r_mem_wdata;
  assign stall      = w_any_req & ~(r_if_ack | r_d_ack);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized single and
// contended transactions checked against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack, if_err;
  logic [31:0] if_rdata;
  logic        d_rd, d_wr;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        stall, mem_re, mem_we;
  logic [7:0]  mem_addr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem_img [256];
  assign mem_rdata = mem_img[mem_addr];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: who was granted last, and the held read-data values.
  bit          model_last_data;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [0:0]  exp_q[$];  // expected ack order: 0 fetch, 1 data

  mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err),
    .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .stall(stall), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_mis(input bit is_f, input logic [2:0] f3, input logic [7:0] a);
    if (is_f) return a[1:0] != 2'b00;
    if (f3[1:0] == 2'b10) return a[1:0] != 2'b00;
    if (f3[1:0] == 2'b01) return a[0];
    return 1'b0;
  endfunction

  // ---------------- driver / monitor ----------------
  // Called at a negedge in an IDLE cycle. Sample 1 is the IDLE cycle in
  // which the request is first visible; returns at a negedge in IDLE.
  task automatic run_txn(input bit is_f, input bit wr, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wd,
                         output int ack_cyc, output bit err, output logic [31:0] rdata,
                         output int re_cnt, output int we_cnt,
                         output logic [7:0] m_addr, output logic [2:0] m_f3,
                         output logic [31:0] m_wd, output int stall_cnt,
                         output bit other_ack);
    ack_cyc = -1; err = 1'b0; rdata = '0; re_cnt = 0; we_cnt = 0;
    m_addr = '0; m_f3 = '0; m_wd = '0; stall_cnt = 0; other_ack = 1'b0;
    if (is_f) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_rd = !wr; d_wr = wr; d_funct3 = f3; d_addr = addr; d_wdata = wd;
    end
    #1;
    for (int k = 1; k <= 20; k++) begin
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if (mem_re || mem_we) begin
        m_addr = mem_addr; m_f3 = mem_funct3; m_wd = mem_wdata;
      end
      if (is_f ? d_ack : if_ack) other_ack = 1'b1;
      if (is_f ? if_ack : d_ack) begin
        ack_cyc = k;
        err = is_f ? if_err : d_err;
        rdata = is_f ? if_rdata : d_rdata;
        break;
      end
      if (stall) stall_cnt++;
      @(negedge clk);
    end
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_model();
    model_last_data = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
    reset_model();
    repeat (3) @(negedge clk);
    vectors++;
    if ({if_ack, if_err, d_ack, d_err, mem_re, mem_we, stall} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000000", {if_ack, if_err, d_ack, d_err, mem_re, mem_we, stall});
    end
    vectors++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata got if=%h d=%h want 0", if_rdata, d_rdata);
    end
    vectors++;
    if (mem_addr !== 8'h0 || mem_funct3 !== 3'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_fields got %h/%h/%h want 0", mem_addr, mem_funct3, mem_wdata);
    end
    rst = 1'b1;  // released at a negedge; the first grant can be on the next posedge
  endtask

  task automatic test_fetch();
    int ack_cyc, re_cnt, we_cnt, stall_cnt; bit err, oth;
    logic [31:0] rd, mwd; logic [7:0] ma; logic [2:0] mf;
    run_txn(1'b1, 1'b0, 3'b010, 8'h10, 32'h0, ack_cyc, err, rd, re_cnt, we_cnt, ma, mf, mwd, stall_cnt, oth);
    vectors++;
    if (ack_cyc !== 4 || stall_cnt !== 3 || err !== 1'b0 || oth !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_timing got ack=%0d stall=%0d err=%0d oth=%0d want 4 3 0 0", ack_cyc, stall_cnt, err, oth);
    end
    vectors++;
    if (rd !== 32'h00500093) begin
      miscompares++;
      $display("FAIL fetch_rdata got %h want 00500093", rd);
    end
    vectors++;
    if (re_cnt !== 1 || we_cnt !== 0 || ma !== 8'h10 || mf !== 3'b010) begin
      miscompares++;
      $display("FAIL fetch_cmd got re=%0d we=%0d addr=%h f3=%b want 1 0 10 010", re_cnt, we_cnt, ma, mf);
    end
    model_last_data = 1'b0; exp_if_rdata = 32'h00500093;
  endtask

  task automatic test_store();
    int ack_cyc, re_cnt, we_cnt, stall_cnt; bit err, oth;
    logic [31:0] rd, mwd; logic [7:0] ma; logic [2:0] mf;
    run_txn(1'b0, 1'b1, 3'b010, 8'h20, 32'hDEADBEEF, ack_cyc, err, rd, re_cnt, we_cnt, ma, mf, mwd, stall_cnt, oth);
    vectors++;
    if (ack_cyc !== 3 || stall_cnt !== 2 || err !== 1'b0 || oth !== 1'b0) begin
      miscompares++;
      $display("FAIL store_timing got ack=%0d stall=%0d err=%0d oth=%0d want 3 2 0 0", ack_cyc, stall_cnt, err, oth);
    end
    vectors++;
    if (re_cnt !== 0 || we_cnt !== 1 || ma !== 8'h20 || mf !== 3'b010 || mwd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_cmd got re=%0d we=%0d addr=%h f3=%b wd=%h want 0 1 20 010 deadbeef",
               re_cnt, we_cnt, ma, mf, mwd);
    end
    vectors++;
    if (rd !== exp_d_rdata) begin
      miscompares++;
      $display("FAIL store_rdata_hold got %h want %h", rd, exp_d_rdata);
    end
    model_last_data = 1'b1;
  endtask

  task automatic test_back_to_back();
    int re1, re2, acks; logic [31:0] rd1, rd2;
    re1 = -1; re2 = -1; acks = 0; rd1 = '0; rd2 = '0;
    d_rd = 1'b1; d_funct3 = 3'b010; d_addr = 8'h04;
    #1;
    for (int k = 1; k <= 20 && acks < 2; k++) begin
      if (mem_re) begin
        if (re1 < 0) re1 = k;
        else if (re2 < 0) re2 = k;
      end
      if (d_ack) begin
        if (acks == 0) begin
          rd1 = d_rdata; d_addr = 8'h08;
        end else begin
          rd2 = d_rdata; d_rd = 1'b0;
        end
        acks++;
      end
      @(negedge clk);
    end
    d_rd = 1'b0;
    vectors++;
    if (acks !== 2 || re1 !== 2 || re2 - re1 !== 4) begin
      miscompares++;
      $display("FAIL b2b_spacing got acks=%0d re1=%0d re2=%0d want 2 2 6", acks, re1, re2);
    end
    vectors++;
    if (rd1 !== mem_img[4] || rd2 !== mem_img[8]) begin
      miscompares++;
      $display("FAIL b2b_rdata got %h %h want %h %h", rd1, rd2, mem_img[4], mem_img[8]);
    end
    model_last_data = 1'b1; exp_d_rdata = mem_img[8];
  endtask

  task automatic test_misaligned();
    int ack_cyc, re_cnt, we_cnt, stall_cnt; bit err, oth;
    logic [31:0] rd, mwd; logic [7:0] ma; logic [2:0] mf;
    run_txn(1'b0, 1'b0, 3'b001, 8'h21, 32'h0, ack_cyc, err, rd, re_cnt, we_cnt, ma, mf, mwd, stall_cnt, oth);
    vectors++;
    if (ack_cyc !== 2 || err !== 1'b1 || oth !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_timing got ack=%0d err=%0d oth=%0d want 2 1 0", ack_cyc, err, oth);
    end
    vectors++;
    if (rd !== 32'h0 || re_cnt !== 0 || we_cnt !== 0) begin
      miscompares++;
      $display("FAIL mis_nomem got rdata=%h re=%0d we=%0d want 0 0 0", rd, re_cnt, we_cnt);
    end
    model_last_data = 1'b1; exp_d_rdata = '0;
  endtask

  task automatic test_drop();
    int ack_k; logic [31:0] rd;
    ack_k = -1; rd = '0;
    d_rd = 1'b1; d_funct3 = 3'b010; d_addr = 8'h30;
    #1;
    for (int k = 1; k <= 10 && ack_k < 0; k++) begin
      if (k == 2) d_rd = 1'b0;  // dropped once the arbiter has sampled it
      if (d_ack) begin
        ack_k = k; rd = d_rdata;
      end
      @(negedge clk);
    end
    vectors++;
    if (ack_k !== 4 || rd !== mem_img[8'h30]) begin
      miscompares++;
      $display("FAIL drop_ack got cyc=%0d rdata=%h want 4 %h", ack_k, rd, mem_img[8'h30]);
    end
    model_last_data = 1'b1; exp_d_rdata = mem_img[8'h30];
  endtask

  task automatic test_reset_abort();
    int ack_cyc, re_cnt, we_cnt, stall_cnt; bit err, oth, saw_ack;
    logic [31:0] rd, mwd; logic [7:0] ma; logic [2:0] mf;
    d_wr = 1'b1; d_funct3 = 3'b010; d_addr = 8'h20; d_wdata = 32'h12345678;
    @(negedge clk);  // ACCESS cycle
    vectors++;
    if (mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_we_before got %b want 1", mem_we);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async got we=%b re=%b want 0 0", mem_we, mem_re);
    end
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) saw_ack = 1'b1;
    end
    d_wr = 1'b0;
    reset_model();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_ack) saw_ack = 1'b1;
    end
    vectors++;
    if (saw_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_ack got ack_seen=%b want 0", saw_ack);
    end
    run_txn(1'b0, 1'b0, 3'b010, 8'h20, 32'h0, ack_cyc, err, rd, re_cnt, we_cnt, ma, mf, mwd, stall_cnt, oth);
    vectors++;
    if (ack_cyc !== 4 || rd !== mem_img[8'h20] || re_cnt !== 1 || we_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_fresh_read got ack=%0d rdata=%h re=%0d we=%0d want 4 %h 1 0",
               ack_cyc, rd, re_cnt, we_cnt, mem_img[8'h20]);
    end
    model_last_data = 1'b1; exp_d_rdata = mem_img[8'h20];
  endtask

  task automatic test_contention();
    int got; logic [0:0] exp; logic got_data;
    rst = 1'b0;
    @(negedge clk);
    reset_model();
    if_req = 1'b1; if_addr = 8'h40;
    d_rd = 1'b1; d_funct3 = 3'b010; d_addr = 8'h44;
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        got_data = d_ack;
        exp = exp_q.pop_front();
        vectors++;
        if ((if_ack && d_ack) || got_data !== exp) begin
          miscompares++;
          $display("FAIL cont_order ack#%0d got if_ack=%b d_ack=%b want data=%b", got, if_ack, d_ack, exp);
        end
        vectors++;
        if (got_data ? (d_rdata !== mem_img[8'h44]) : (if_rdata !== mem_img[8'h40])) begin
          miscompares++;
          $display("FAIL cont_rdata ack#%0d got if=%h d=%h", got, if_rdata, d_rdata);
        end
        got++;
      end
    end
    if_req = 1'b0; d_rd = 1'b0;
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL cont_count got %0d want 4", got);
    end
    @(negedge clk);
    model_last_data = 1'b1; exp_if_rdata = mem_img[8'h40]; exp_d_rdata = mem_img[8'h44];
  endtask

  task automatic test_random_single();
    int ack_cyc, re_cnt, we_cnt, stall_cnt, exp_ack, kind; bit err, oth, is_f, wr, mis;
    logic [31:0] rd, mwd, wd, exp_rd; logic [7:0] ma, addr; logic [2:0] mf, f3;
    logic [2:0] ld_tab [5];
    ld_tab[0] = 3'b000; ld_tab[1] = 3'b001; ld_tab[2] = 3'b010; ld_tab[3] = 3'b100; ld_tab[4] = 3'b101;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      is_f = (kind == 0); wr = (kind == 2);
      f3 = is_f ? 3'b010 : (wr ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)]);
      addr = 8'($urandom);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd = $urandom;
      mis = is_mis(is_f, f3, addr);
      exp_ack = mis ? 2 : (wr ? 3 : 4);
      if (mis) exp_rd = '0;
      else if (wr) exp_rd = exp_d_rdata;
      else exp_rd = mem_img[addr];
      run_txn(is_f, wr, f3, addr, wd, ack_cyc, err, rd, re_cnt, we_cnt, ma, mf, mwd, stall_cnt, oth);
      vectors++;
      if (ack_cyc !== exp_ack || stall_cnt !== exp_ack - 1 || err !== mis || oth !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_timing n=%0d f=%0d wr=%0d f3=%b a=%h got ack=%0d stall=%0d err=%0d oth=%0d want %0d %0d %0d 0",
                 n, is_f, wr, f3, addr, ack_cyc, stall_cnt, err, oth, exp_ack, exp_ack - 1, mis);
      end
      vectors++;
      if (rd !== exp_rd) begin
        miscompares++;
        $display("FAIL rnd_rdata n=%0d got %h want %h", n, rd, exp_rd);
      end
      vectors++;
      if (re_cnt !== int'(!mis && !wr) || we_cnt !== int'(!mis && wr)) begin
        miscompares++;
        $display("FAIL rnd_strobes n=%0d got re=%0d we=%0d want %0d %0d", n, re_cnt, we_cnt,
                 int'(!mis && !wr), int'(!mis && wr));
      end
      if (!mis) begin
        vectors++;
        if (ma !== addr || mf !== f3 || (wr && mwd !== wd)) begin
          miscompares++;
          $display("FAIL rnd_fields n=%0d got %h/%b/%h want %h/%b/%h", n, ma, mf, mwd, addr, f3, wd);
        end
      end
      model_last_data = !is_f;
      if (is_f) exp_if_rdata = exp_rd;
      else exp_d_rdata = exp_rd;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_random_contention();
    int got; bit dwr; logic [0:0] exp, winner; logic got_data;
    logic [7:0] fa, da;
    for (int r = 0; r < 10; r++) begin
      fa = 8'($urandom) & 8'hFC; da = 8'($urandom) & 8'hFC; dwr = 1'($urandom_range(0, 1));
      winner = model_last_data ? 1'b0 : 1'b1;
      exp_q.delete();
      exp_q.push_back(winner); exp_q.push_back(~winner);
      if_req = 1'b1; if_addr = fa;
      d_rd = !dwr; d_wr = dwr; d_funct3 = 3'b010; d_addr = da; d_wdata = $urandom;
      got = 0;
      for (int k = 0; k < 30 && got < 2; k++) begin
        @(negedge clk);
        if (if_ack || d_ack) begin
          got_data = d_ack;
          exp = exp_q.pop_front();
          vectors++;
          if ((if_ack && d_ack) || got_data !== exp) begin
            miscompares++;
            $display("FAIL rcont_order r=%0d got if_ack=%b d_ack=%b want data=%b", r, if_ack, d_ack, exp);
          end
          if (if_ack) begin
            vectors++;
            if (if_rdata !== mem_img[fa]) begin
              miscompares++;
              $display("FAIL rcont_if_rdata r=%0d got %h want %h", r, if_rdata, mem_img[fa]);
            end
            if_req = 1'b0; exp_if_rdata = mem_img[fa];
          end else begin
            vectors++;
            if (d_rdata !== (dwr ? exp_d_rdata : mem_img[da])) begin
              miscompares++;
              $display("FAIL rcont_d_rdata r=%0d got %h want %h", r, d_rdata, dwr ? exp_d_rdata : mem_img[da]);
            end
            d_rd = 1'b0; d_wr = 1'b0;
            if (!dwr) exp_d_rdata = mem_img[da];
          end
          model_last_data = got_data;
          got++;
        end
      end
      if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      vectors++;
      if (got !== 2) begin
        miscompares++;
        $display("FAIL rcont_count r=%0d got %0d want 2", r, got);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = $urandom ^ 32'(i + 1);
    mem_img[8'h10] = 32'h00500093;
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_misaligned();
    test_drop();
    test_reset_abort();
    test_contention();
    test_random_single();
    test_random_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
